// File: rtl/mont_mul_param.sv
// Radix-2 Montgomery modular multiplier: result = a*b*2^(-WIDTH) mod n.
// One serial iteration per clock, followed by a single conditional-subtract
// cycle. Even moduli are rejected immediately with err raised alongside done.
module mont_mul_param #(
    parameter int WIDTH = 256,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        REDUCE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH+1:0] acc;
    logic [CNT_W-1:0] cnt;

    // One Montgomery step: add b if the current multiplier bit is set, make the
    // sum even by adding n, then halve. acc < 2n and b < n keep every sum < 4n,
    // so two guard bits above WIDTH are enough.
    function automatic logic [WIDTH+1:0] mont_step(
        input logic [WIDTH+1:0] acc_in,
        input logic             a_bit,
        input logic [WIDTH-1:0] b_in,
        input logic [WIDTH-1:0] n_in
    );
        logic [WIDTH+1:0] t;
        t = acc_in + (a_bit ? {2'b00, b_in} : {(WIDTH + 2){1'b0}});
        if (t[0]) begin
            t = t + {2'b00, n_in};
        end
        return t >> 1;
    endfunction

    // Final correction: the accumulator lands in [0, 2n), one subtraction
    // brings it into [0, n).
    function automatic logic [WIDTH-1:0] final_sub(
        input logic [WIDTH+1:0] acc_in,
        input logic [WIDTH-1:0] n_in
    );
        logic [WIDTH+1:0] n_ext;
        logic [WIDTH+1:0] red;
        n_ext = {2'b00, n_in};
        if (acc_in >= n_ext) begin
            red = acc_in - n_ext;
        end else begin
            red = acc_in;
        end
        return red[WIDTH-1:0];
    endfunction

    assign busy = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: even moduli never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && n[0]) begin
                    state_d = ITER;
                end
            end
            ITER: begin
                if (cnt == LAST_ITER) begin
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, serial iteration, final reduction and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            n_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        n_reg <= n;
                        acc   <= '0;
                        cnt   <= '0;
                        err   <= ~n[0];
                        if (!n[0]) begin
                            done   <= 1'b1;
                            result <= '0;
                        end
                    end
                end
                ITER: begin
                    acc   <= mont_step(acc, a_reg[0], b_reg, n_reg);
                    a_reg <= a_reg >> 1;
                    cnt   <= cnt + 1'b1;
                end
                REDUCE: begin
                    result <= final_sub(acc, n_reg);
                    done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul_param.sv
// Bench for mont_mul_param: an 8-bit instance driven with hand-computed
// vectors and a 256-bit instance checked against a modular-halving model.
// Drivers push expected responses; monitors pop and compare on each done.
module tb_mont_mul_param;

    localparam int W8 = 8;
    localparam int WW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // 8-bit instance
    logic          rst8, start8, busy8, done8, err8;
    logic [W8-1:0] a8, b8, n8, result8;

    mont_mul_param #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .n(n8),
        .busy(busy8), .done(done8), .err(err8), .result(result8)
    );

    // 256-bit instance
    logic          rstw, startw, busyw, donew, errw;
    logic [WW-1:0] aw, bw, nw, resultw;

    mont_mul_param #(.WIDTH(WW)) dutw (
        .clk(clk), .rst(rstw), .start(startw), .a(aw), .b(bw), .n(nw),
        .busy(busyw), .done(donew), .err(errw), .result(resultw)
    );

    typedef struct {
        logic [WW-1:0] res;
        logic [WW-1:0] n;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t q8[$];
    exp_t qw[$];
    exp_t m8_e;
    exp_t mw_e;

    task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: reduce a*b mod n, then halve mod n WIDTH times.
    function automatic logic [WW-1:0] ref_mont(input logic [WW-1:0] ra, input logic [WW-1:0] rb,
                                               input logic [WW-1:0] rn);
        logic [2*WW:0] p;
        logic [2*WW:0] m;
        logic [WW+1:0] x;
        p = {{(WW + 1){1'b0}}, ra} * {{(WW + 1){1'b0}}, rb};
        m = p % {{(WW + 1){1'b0}}, rn};
        x = m[WW+1:0];
        for (int i = 0; i < WW; i++) begin
            if (x[0]) x = x + {2'b00, rn};
            x = x >> 1;
        end
        return x[WW-1:0];
    endfunction

    function automatic logic [WW-1:0] rand256();
        logic [WW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at a negedge: present operands and raise start for the next edge.
    task automatic drive8(input logic [W8-1:0] va, input logic [W8-1:0] vb, input logic [W8-1:0] vn,
                          input logic [W8-1:0] res, input logic e);
        exp_t x;
        a8 = va; b8 = vb; n8 = vn; start8 = 1'b1;
        x.res = {{(WW - W8){1'b0}}, res};
        x.n   = {{(WW - W8){1'b0}}, vn};
        x.err = e;
        x.cyc = e ? cyc + 1 : cyc + W8 + 2;
        q8.push_back(x);
    endtask

    task automatic wait8(output int bsy);
        bsy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) return;
            if (busy8) bsy++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL timeout8: no done within 40 cycles, required done");
    endtask

    task automatic drivew(input logic [WW-1:0] va, input logic [WW-1:0] vb, input logic [WW-1:0] vn,
                          input logic [WW-1:0] res);
        exp_t x;
        aw = va; bw = vb; nw = vn; startw = 1'b1;
        x.res = res;
        x.n   = vn;
        x.err = 1'b0;
        x.cyc = cyc + WW + 2;
        qw.push_back(x);
    endtask

    task automatic waitw();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            startw = 1'b0;
            if (donew) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL timeoutw: no done within 300 cycles, required done");
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done8: done=1 with no outstanding request (cycle %0d)", cyc);
            end else begin
                m8_e = q8.pop_front();
                check("result8", {{(WW - W8){1'b0}}, result8}, m8_e.res);
                check("err8", {{(WW - 1){1'b0}}, err8}, {{(WW - 1){1'b0}}, m8_e.err});
                check("latency8", cyc, m8_e.cyc);
                check("busy_at_done8", {{(WW - 1){1'b0}}, busy8}, '0);
                if (!m8_e.err) begin
                    check("result8_lt_n", {{(WW - 1){1'b0}}, ({{(WW - W8){1'b0}}, result8} < m8_e.n)},
                          {{(WW - 1){1'b0}}, 1'b1});
                end
            end
        end
    end

    // Monitor for the 256-bit instance
    always @(negedge clk) begin
        if (donew) begin
            if (qw.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_donew: done=1 with no outstanding request (cycle %0d)", cyc);
            end else begin
                mw_e = qw.pop_front();
                check("resultw", resultw, mw_e.res);
                check("errw", {{(WW - 1){1'b0}}, errw}, '0);
                check("latencyw", cyc, mw_e.cyc);
                check("resultw_lt_n", {{(WW - 1){1'b0}}, (resultw < mw_e.n)}, {{(WW - 1){1'b0}}, 1'b1});
            end
        end
    end

    task automatic test8();
        int bsy;
        int spur;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; n8 = '0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        @(negedge clk);
        check("rst_busy8", {{(WW - 1){1'b0}}, busy8}, '0);
        check("rst_done8", {{(WW - 1){1'b0}}, done8}, '0);
        check("rst_err8", {{(WW - 1){1'b0}}, err8}, '0);
        check("rst_result8", {{(WW - W8){1'b0}}, result8}, '0);

        // 5*7*2^-8 mod 13 = 35*3 mod 13 = 1
        drive8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0);
        wait8(bsy);
        check("busy_cycles8", bsy, 9);

        // Back-to-back, each start in the previous done cycle
        drive8(8'd12, 8'd12, 8'd13, 8'd3, 1'b0);
        wait8(bsy);
        drive8(8'd1, 8'd1, 8'd13, 8'd3, 1'b0);
        wait8(bsy);
        drive8(8'd0, 8'd9, 8'd13, 8'd0, 1'b0);
        wait8(bsy);

        // Even modulus
        @(negedge clk);
        drive8(8'd3, 8'd5, 8'd12, 8'd0, 1'b1);
        wait8(bsy);
        check("even_busy_cycles8", bsy, 0);
        @(negedge clk);
        @(negedge clk);
        check("err_held8", {{(WW - 1){1'b0}}, err8}, {{(WW - 1){1'b0}}, 1'b1});
        check("done_pulse8", {{(WW - 1){1'b0}}, done8}, '0);
        drive8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        check("err_cleared8", {{(WW - 1){1'b0}}, err8}, '0);
        check("busy_after_start8", {{(WW - 1){1'b0}}, busy8}, {{(WW - 1){1'b0}}, 1'b1});
        wait8(bsy);

        // Starts while busy are ignored
        @(negedge clk);
        drive8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd0;
        wait8(bsy);

        // Reset during iteration 4 aborts without a done pulse
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; n8 = 8'd13; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("abort_busy8", {{(WW - 1){1'b0}}, busy8}, '0);
        check("abort_done8", {{(WW - 1){1'b0}}, done8}, '0);
        check("abort_result8", {{(WW - W8){1'b0}}, result8}, '0);
        spur = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) spur++;
        end
        check("abort_no_done8", spur, 0);
        drive8(8'd12, 8'd12, 8'd13, 8'd3, 1'b0);
        wait8(bsy);
    endtask

    task automatic testw();
        logic [WW-1:0] va, vb, vn;
        logic [WW-1:0] nmax;
        nmax = '1;
        rstw = 1'b1; startw = 1'b0; aw = '0; bw = '0; nw = '0;
        repeat (3) @(negedge clk);
        rstw = 1'b0;
        @(negedge clk);
        check("rst_resultw", resultw, '0);

        // n = 2^256-1 makes 2^256 congruent to 1, so result = a*b mod n
        drivew(256'd5, 256'd7, nmax, 256'd35);
        waitw();
        drivew(nmax, 256'd7, nmax, '0);
        waitw();
        vn = rand256();
        vn[0] = 1'b1;
        drivew('0, vn - 1'b1, vn, '0);
        waitw();

        for (int i = 0; i < 40; i++) begin
            va = rand256();
            vn = rand256();
            vn[0] = 1'b1;
            if (i % 2 == 0) vn[WW-1] = 1'b1;
            vb = rand256() % vn;
            drivew(va, vb, vn, ref_mont(va, vb, vn));
            waitw();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            test8();
            testw();
        join
        repeat (3) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("qw_drained", qw.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
